// File: rtl/bf_core_stream.sv
// bf_core_stream -- Brainfuck execution core with streaming character I/O.
//
// A program is written into code memory through the prog_* port while the
// core is idle. A start pulse clears data memory, one cell per cycle, and
// then runs the program from pc=0 at one instruction per cycle. Characters
// move through valid/ready streams. The outcome of a run is reported on the
// sticky done/error outputs.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start, stop           restart a run (clear then execute) / abort to idle
//   prog_we/addr/data     code memory write port, honoured only when idle
//   in_valid/ready/data   input character stream (',' instruction)
//   out_valid/ready/data  output character stream ('.' instruction)
//   busy                  core is not idle
//   done                  sticky, normal halt reached
//   error                 sticky, 0 none, 1 unmatched bracket,
//                         2 stack overflow, 3 stack underflow
//
// Build option: define BF_LOOP_STACK_EN to add a hardware loop stack of
// STACK_DEPTH entries. With the stack, ']' jumps back in a single cycle
// instead of scanning backwards for its '['.

module bf_core_stream #(
  parameter int CELL_W      = 8,
  parameter int DATA_AW     = 8,
  parameter int CODE_AW     = 8,
  parameter int STACK_DEPTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               prog_we,
  input  logic [CODE_AW-1:0] prog_addr,
  input  logic [3:0]         prog_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CELL_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CELL_W-1:0]  out_data,
  output logic               busy,
  output logic               done,
  output logic [1:0]         error
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_EXEC, S_SCAN_F, S_SCAN_B, S_WAIT_IN, S_WAIT_OUT
  } state_e;

  // How the program counter moves at the end of a cycle.
  typedef enum logic [1:0] {PC_KEEP, PC_ADV, PC_FWD, PC_BACK} pc_act_e;

  localparam logic [3:0] OP_RIGHT = 4'd0;
  localparam logic [3:0] OP_LEFT  = 4'd1;
  localparam logic [3:0] OP_INC   = 4'd2;
  localparam logic [3:0] OP_DEC   = 4'd3;
  localparam logic [3:0] OP_OUT   = 4'd4;
  localparam logic [3:0] OP_IN    = 4'd5;
  localparam logic [3:0] OP_LOOP  = 4'd6;
  localparam logic [3:0] OP_END   = 4'd7;

  localparam logic [CODE_AW-1:0] PC_MAX  = {CODE_AW{1'b1}};
  localparam logic [DATA_AW-1:0] PTR_MAX = {DATA_AW{1'b1}};
  localparam logic [CODE_AW:0]   CNT_ONE = (CODE_AW+1)'(1);

  logic [3:0]        code_mem [2**CODE_AW];
  logic [CELL_W-1:0] data_mem [2**DATA_AW];

  state_e             state_q, state_d;
  logic [CODE_AW-1:0] pc_q, pc_d;
  logic [DATA_AW-1:0] ptr_q, ptr_d;
  logic [CODE_AW:0]   count_q, count_d;
  logic [CELL_W-1:0]  out_data_q, out_data_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         error_q, error_d;

  pc_act_e            pc_act_s;
  logic [3:0]         op_s;
  logic [CELL_W-1:0]  cell_s;
  logic               cm_we_s;
  logic               dm_we_s;
  logic [CELL_W-1:0]  dm_wdata_s;

`ifdef BF_LOOP_STACK_EN
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [CODE_AW-1:0] stk_mem [STACK_DEPTH];
  logic [SP_W-1:0]    sp_q, sp_d;
  logic [SP_W-1:0]    sp_dec_s;
  logic [CODE_AW-1:0] stk_top_s;
  logic               stk_we_s;

  assign sp_dec_s  = sp_q - SP_W'(1);
  assign stk_top_s = stk_mem[sp_dec_s[SI_W-1:0]];
`endif

  assign op_s   = code_mem[pc_q];
  assign cell_s = data_mem[ptr_q];

  // Next-state, datapath and output logic for the whole core.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    done_d      = done_q;
    error_d     = error_q;
    pc_act_s    = PC_KEEP;
    cm_we_s     = 1'b0;
    dm_we_s     = 1'b0;
    dm_wdata_s  = {CELL_W{1'b0}};
`ifdef BF_LOOP_STACK_EN
    sp_d        = sp_q;
    stk_we_s    = 1'b0;
`endif

    if (stop) begin
      state_d = S_IDLE;
    end else if (start) begin
      state_d = S_CLEAR;
      pc_d    = {CODE_AW{1'b0}};
      ptr_d   = {DATA_AW{1'b0}};
      done_d  = 1'b0;
      error_d = 2'd0;
`ifdef BF_LOOP_STACK_EN
      sp_d    = {SP_W{1'b0}};
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          cm_we_s = prog_we;
        end
        S_CLEAR: begin
          // ptr doubles as the clear address and wraps back to 0 at the end.
          dm_we_s = 1'b1;
          ptr_d   = ptr_q + DATA_AW'(1);
          if (ptr_q == PTR_MAX) begin
            state_d = S_EXEC;
            pc_d    = {CODE_AW{1'b0}};
          end else begin
            state_d = S_CLEAR;
          end
        end
        S_EXEC: begin
          case (op_s)
            OP_RIGHT: begin ptr_d = ptr_q + DATA_AW'(1); pc_act_s = PC_ADV; end
            OP_LEFT:  begin ptr_d = ptr_q - DATA_AW'(1); pc_act_s = PC_ADV; end
            OP_INC: begin
              dm_we_s    = 1'b1;
              dm_wdata_s = cell_s + CELL_W'(1);
              pc_act_s   = PC_ADV;
            end
            OP_DEC: begin
              dm_we_s    = 1'b1;
              dm_wdata_s = cell_s - CELL_W'(1);
              pc_act_s   = PC_ADV;
            end
            OP_OUT: begin
              out_data_d = cell_s;
              state_d    = S_WAIT_OUT;
            end
            OP_IN: begin
              state_d = S_WAIT_IN;
            end
            OP_LOOP: begin
              if (cell_s == {CELL_W{1'b0}}) begin
                count_d  = CNT_ONE;
                state_d  = S_SCAN_F;
                pc_act_s = PC_FWD;
              end else begin
`ifdef BF_LOOP_STACK_EN
                if (sp_q == SP_FULL) begin
                  error_d = 2'd2;
                  state_d = S_IDLE;
                end else begin
                  stk_we_s = 1'b1;
                  sp_d     = sp_q + SP_W'(1);
                  pc_act_s = PC_ADV;
                end
`else
                pc_act_s = PC_ADV;
`endif
              end
            end
            OP_END: begin
              if (cell_s != {CELL_W{1'b0}}) begin
`ifdef BF_LOOP_STACK_EN
                if (sp_q == {SP_W{1'b0}}) begin
                  error_d = 2'd3;
                  state_d = S_IDLE;
                end else begin
                  pc_d = stk_top_s + CODE_AW'(1);
                end
`else
                count_d  = CNT_ONE;
                state_d  = S_SCAN_B;
                pc_act_s = PC_BACK;
`endif
              end else begin
`ifdef BF_LOOP_STACK_EN
                if (sp_q == {SP_W{1'b0}}) begin
                  error_d = 2'd3;
                  state_d = S_IDLE;
                end else begin
                  sp_d     = sp_dec_s;
                  pc_act_s = PC_ADV;
                end
`else
                pc_act_s = PC_ADV;
`endif
              end
            end
            default: begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
        S_SCAN_F: begin
          case (op_s)
            OP_LOOP: begin count_d = count_q + CNT_ONE; pc_act_s = PC_FWD; end
            OP_END: begin
              if (count_q == CNT_ONE) begin
                state_d  = S_EXEC;
                pc_act_s = PC_ADV;
              end else begin
                count_d  = count_q - CNT_ONE;
                pc_act_s = PC_FWD;
              end
            end
            default: pc_act_s = PC_FWD;
          endcase
        end
        S_SCAN_B: begin
          case (op_s)
            OP_END: begin count_d = count_q + CNT_ONE; pc_act_s = PC_BACK; end
            OP_LOOP: begin
              if (count_q == CNT_ONE) begin
                state_d  = S_EXEC;
                pc_act_s = PC_ADV;
              end else begin
                count_d  = count_q - CNT_ONE;
                pc_act_s = PC_BACK;
              end
            end
            default: pc_act_s = PC_BACK;
          endcase
        end
        S_WAIT_IN: begin
          if (in_valid) begin
            dm_we_s    = 1'b1;
            dm_wdata_s = in_data;
            state_d    = S_EXEC;
            pc_act_s   = PC_ADV;
          end else begin
            state_d = S_WAIT_IN;
          end
        end
        S_WAIT_OUT: begin
          if (out_ready) begin
            state_d  = S_EXEC;
            pc_act_s = PC_ADV;
          end else begin
            state_d = S_WAIT_OUT;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Stepping past either end of code memory ends the run: a normal
      // advance halts cleanly, a bracket scan reports an unmatched bracket.
      case (pc_act_s)
        PC_ADV: begin
          if (pc_q == PC_MAX) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            pc_d = pc_q + CODE_AW'(1);
          end
        end
        PC_FWD: begin
          if (pc_q == PC_MAX) begin
            error_d = 2'd1;
            state_d = S_IDLE;
          end else begin
            pc_d = pc_q + CODE_AW'(1);
          end
        end
        PC_BACK: begin
          if (pc_q == {CODE_AW{1'b0}}) begin
            error_d = 2'd1;
            state_d = S_IDLE;
          end else begin
            pc_d = pc_q - CODE_AW'(1);
          end
        end
        default: ;
      endcase
    end

    busy_d      = (state_d != S_IDLE);
    in_ready_d  = (state_d == S_WAIT_IN);
    out_valid_d = (state_d == S_WAIT_OUT);
  end

  // Control and status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= {CODE_AW{1'b0}};
      ptr_q       <= {DATA_AW{1'b0}};
      count_q     <= {(CODE_AW+1){1'b0}};
      out_data_q  <= {CELL_W{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 2'd0;
`ifdef BF_LOOP_STACK_EN
      sp_q        <= {SP_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef BF_LOOP_STACK_EN
      sp_q        <= sp_d;
`endif
    end
  end

  // Code and data memories; reset leaves their contents alone.
  always_ff @(posedge clock) begin
    if (!reset && cm_we_s) begin
      code_mem[prog_addr] <= prog_data;
    end
    if (!reset && dm_we_s) begin
      data_mem[ptr_q] <= dm_wdata_s;
    end
  end

`ifdef BF_LOOP_STACK_EN
  // Loop stack storage, holding the pc of each open '['.
  always_ff @(posedge clock) begin
    if (!reset && stk_we_s) begin
      stk_mem[sp_q[SI_W-1:0]] <= pc_q;
    end
  end
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
